// File: rtl/eth_tx_frame_fifo.sv
// eth_tx_frame_fifo: store-and-forward byte FIFO in front of the GMII transmitter.
// A frame becomes visible on the master side only after its tlast byte is
// committed, so the transmitter never sees tvalid drop mid-frame. Frames
// flagged bad on tlast, or longer than the buffer, are discarded whole.
module eth_tx_frame_fifo #(
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,

    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,

    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,

    output logic       status_good_frame,
    output logic       status_bad_frame,
    output logic       status_overflow
);

    // DEPTH expressed in pointer width (pointers carry one wrap bit)
    localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        WR_WRITE = 1'b0,
        WR_DROP  = 1'b1
    } wr_state_t;

    // {tlast, tdata} per entry
    logic [8:0]            mem [DEPTH];

    wr_state_t             state_q;
    logic [ADDR_WIDTH:0]   wr_ptr_q;
    logic [ADDR_WIDTH:0]   commit_ptr_q;
    logic [ADDR_WIDTH:0]   rd_ptr_q;
    logic                  good_q;
    logic                  bad_q;
    logic                  ovf_q;
    logic [7:0]            m_data_q;
    logic                  m_last_q;
    logic                  m_valid_q;

    logic [ADDR_WIDTH:0]   wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_d;
    logic                  full;
    logic                  wr_accept;
    logic                  len_at_limit;
    logic                  rd_en;

    // Occupancy is measured against rd_ptr, so committed-but-undrained frames
    // cause backpressure rather than a drop.
    always_comb begin
        wr_ptr_d      = wr_ptr_q + 1'b1;
        rd_ptr_d      = rd_ptr_q + 1'b1;
        full          = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
        s_axis_tready = !rst && ((state_q == WR_DROP) || !full);
        wr_accept     = s_axis_tvalid && s_axis_tready;
        // The current frame would reach DEPTH bytes without ending: it cannot fit
        len_at_limit  = (wr_ptr_d - commit_ptr_q) == DEPTH_P;
        rd_en         = (rd_ptr_q != commit_ptr_q) && (!m_valid_q || m_axis_tready);
    end

    // Write-side FSM: speculative write pointer, commit on good tlast, rewind on bad/overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WR_WRITE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            good_q <= 1'b0;
            bad_q  <= 1'b0;
            ovf_q  <= 1'b0;
            case (state_q)
                WR_WRITE: begin
                    if (wr_accept) begin
                        if (s_axis_tlast) begin
                            if (s_axis_tuser) begin
                                wr_ptr_q <= commit_ptr_q;
                                bad_q    <= 1'b1;
                            end else begin
                                wr_ptr_q     <= wr_ptr_d;
                                commit_ptr_q <= wr_ptr_d;
                                good_q       <= 1'b1;
                            end
                        end else if (len_at_limit) begin
                            wr_ptr_q <= commit_ptr_q;
                            ovf_q    <= 1'b1;
                            state_q  <= WR_DROP;
                        end else begin
                            wr_ptr_q <= wr_ptr_d;
                        end
                    end
                end
                WR_DROP: begin
                    // Swallow the rest of the oversized frame silently
                    if (wr_accept && s_axis_tlast) begin
                        state_q <= WR_WRITE;
                    end
                end
                default: state_q <= WR_WRITE;
            endcase
        end
    end

    // Byte storage; entries written while dropping are never committed
    always_ff @(posedge clk) begin
        if (wr_accept && (state_q == WR_WRITE)) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Read side: synchronous RAM read lands straight in the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else if (rd_en) begin
            {m_last_q, m_data_q} <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            m_valid_q            <= 1'b1;
            rd_ptr_q             <= rd_ptr_d;
        end else if (m_axis_tready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_axis_tdata      = m_data_q;
    assign m_axis_tlast      = m_last_q;
    assign m_axis_tvalid     = m_valid_q;
    assign m_axis_tuser      = 1'b0;
    assign status_good_frame = good_q;
    assign status_bad_frame  = bad_q;
    assign status_overflow   = ovf_q;

endmodule
